// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line write-through data cache controller for the MEM stage.
// Optional hit/miss performance counters are enabled with `define DCACHE_PERF_CNT_EN.
`timescale 1ns/1ps
module dcache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              DataRead,
  input  logic              DataWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, RESP} state_t;

  state_t              state_reg;
  logic [LINES-1:0]    valid_reg;
  logic [DATA_W-1:0]   resp_reg;
  logic [TAG_W-1:0]    tag_arr  [LINES];
  logic [DATA_W-1:0]   data_arr [LINES];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                req_wr;
  logic                req_rd;

  assign idx    = address[IDX_W-1:0];
  assign tag    = address[ADDR_W-1:IDX_W];
  assign hit    = valid_reg[idx] && (tag_arr[idx] == tag);
  assign req_wr = DataWrite;
  assign req_rd = DataRead && !DataWrite;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      resp_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_wr)
            state_reg <= WR_MEM;
          else if (req_rd && !hit)
            state_reg <= RD_MISS;
        end
        RD_MISS: begin
          if (mem_ack) begin
            valid_reg[idx] <= 1'b1;
            resp_reg       <= mem_rdata;
            state_reg      <= RESP;
          end
        end
        WR_MEM: begin
          if (mem_ack) begin
            resp_reg  <= '0;
            state_reg <= RESP;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag/data store carries no reset; valid_reg alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && req_wr && hit)
      data_arr[idx] <= data;
    if (state_reg == RD_MISS && mem_ack) begin
      data_arr[idx] <= mem_rdata;
      tag_arr[idx]  <= tag;
    end
  end

  always_comb begin
    data_out  = '0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n) begin
      case (state_reg)
        IDLE: begin
          if (req_wr)
            stall = 1'b1;
          else if (req_rd) begin
            if (hit)
              data_out = data_arr[idx];
            else
              stall = 1'b1;
          end
        end
        RD_MISS: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = address;
        end
        WR_MEM: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = address;
          mem_wdata = data;
        end
        default: data_out = resp_reg;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Saturating counters: a wrapped count would read as a near-zero rate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_reg == IDLE && req_rd) begin
      if (hit && hit_cnt != 32'hFFFF_FFFF)
        hit_cnt <= hit_cnt + 32'd1;
      if (!hit && miss_cnt != 32'hFFFF_FFFF)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: transaction-level cache model plus per-cycle output compare.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        DataRead, DataWrite;
  logic [7:0]  address;
  logic [31:0] data;
  logic [31:0] data_out;
  logic        stall, mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .DataRead(DataRead), .DataWrite(DataWrite),
    .address(address), .data(data),
    .data_out(data_out), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference cache contents and statistics
  bit          m_valid [16];
  logic [3:0]  m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] m_hit = 0;
  logic [31:0] m_miss = 0;

  // Expected outputs for the current cycle
  bit          chk_en = 1'b0;
  logic        e_stall, e_req, e_we;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic s, input logic r, input logic w,
                         input logic [7:0] a, input logic [31:0] wd, input logic [31:0] dout);
    e_stall = s; e_req = r; e_we = w; e_addr = a; e_wdata = wd; e_dout = dout;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("data_out", data_out, e_dout);
      chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      chk("mem_addr", {24'd0, mem_addr}, {24'd0, e_addr});
      chk("mem_wdata", mem_wdata, e_wdata);
`ifdef DCACHE_PERF_CNT_EN
      chk("hit_cnt", hit_cnt, m_hit);
      chk("miss_cnt", miss_cnt, m_miss);
`endif
    end
  end

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hit = 0;
    m_miss = 0;
  endfunction

  // Entered at posedge+1; returns at posedge+1 of the cycle after the transaction.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      DataRead = 1'b0; DataWrite = 1'b0;
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      set_exp(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic do_txn(input logic wr, input logic rd, input logic [7:0] a,
                        input logic [31:0] d, input int dly, input logic [31:0] rdat,
                        output logic [31:0] got, output int stalls);
    logic [3:0] ix;
    logic [3:0] tg;
    bit hit, is_rd;
    ix = a[3:0];
    tg = a[7:4];
    hit = m_valid[ix] && (m_tag[ix] == tg);
    is_rd = rd && !wr;
    stalls = 0;
    DataRead = rd; DataWrite = wr; address = a; data = d;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    if (is_rd && hit) begin
      set_exp(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, m_data[ix]);
      @(negedge clk); got = data_out;
      @(posedge clk); #1;
      m_hit++;
    end else begin
      set_exp(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      @(negedge clk); if (stall) stalls++;
      @(posedge clk); #1;
      if (is_rd) m_miss++;
      for (int k = 1; k <= dly; k++) begin
        mem_ack = (k == dly);
        mem_rdata = (k == dly) ? rdat : $urandom;
        set_exp(1'b1, 1'b1, wr, a, wr ? d : 32'h0, 32'h0);
        @(negedge clk); if (stall) stalls++;
        @(posedge clk); #1;
      end
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      set_exp(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, wr ? 32'h0 : rdat);
      @(negedge clk); got = data_out; if (stall) stalls++;
      @(posedge clk); #1;
      if (wr) begin
        if (hit) m_data[ix] = d;
      end else begin
        m_valid[ix] = 1'b1; m_tag[ix] = tg; m_data[ix] = rdat;
      end
    end
    DataRead = 1'b0; DataWrite = 1'b0; mem_ack = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    int st;
    reset_n = 1'b0; DataRead = 1'b0; DataWrite = 1'b0; address = 8'h00; data = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    clear_model();
    set_exp(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    #2;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Read miss fill, then hit
    do_txn(1'b0, 1'b1, 8'h15, 32'h0, 3, 32'hDEAD_BEEF, got, st);
    chk("p1_data", got, 32'hDEAD_BEEF);
    chk("p1_stalls", st, 4);
    do_txn(1'b0, 1'b1, 8'h15, 32'h0, 1, 32'h0, got, st);
    chk("p2_hit_data", got, 32'hDEAD_BEEF);
    chk("p2_stalls", st, 0);
    // Write-through hit updates the line
    do_txn(1'b1, 1'b0, 8'h15, 32'h1234_5678, 2, 32'h0, got, st);
    chk("p3_wr_stalls", st, 3);
    chk("p3_wr_resp", got, 32'h0);
    do_txn(1'b0, 1'b1, 8'h15, 32'h0, 1, 32'h0, got, st);
    chk("p3_rd_data", got, 32'h1234_5678);
    chk("p3_rd_stalls", st, 0);
    // Index aliasing replaces the line
    do_txn(1'b0, 1'b1, 8'h25, 32'h0, 1, 32'hA5A5_A5A5, got, st);
    chk("p4_alias_data", got, 32'hA5A5_A5A5);
    chk("p4_alias_stalls", st, 2);
    do_txn(1'b0, 1'b1, 8'h15, 32'h0, 1, 32'h1234_5678, got, st);
    chk("p4_refill_stalls", st, 2);
    // Read+write together is a write; write miss does not allocate
    do_txn(1'b1, 1'b1, 8'h03, 32'hCAFE_0003, 1, 32'h0, got, st);
    chk("p5_wr_stalls", st, 2);
    do_txn(1'b0, 1'b1, 8'h03, 32'h0, 1, 32'h0BAD_F00D, got, st);
    chk("p5_rd_miss_stalls", st, 2);
    idle(1);

    // Reset during a fill
    DataRead = 1'b1; DataWrite = 1'b0; address = 8'h47; mem_ack = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    @(posedge clk); #1;
    m_miss++;
    set_exp(1'b1, 1'b1, 1'b0, 8'h47, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("p6_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("p6_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_model();
    chk_en = 1'b1;
    do_txn(1'b0, 1'b1, 8'h47, 32'h0, 2, 32'h7777_0047, got, st);
    chk("p6_after_rst_stalls", st, 3);
    chk("p6_after_rst_data", got, 32'h7777_0047);
`ifdef DCACHE_PERF_CNT_EN
    chk("p6_hit_cnt", hit_cnt, 32'd0);
    chk("p6_miss_cnt", miss_cnt, 32'd1);
`endif

    // Randomized traffic over a small address window so hits and aliasing are common
    for (int t = 0; t < 300; t++) begin
      logic [7:0] a;
      logic wr, rd;
      a = 8'($urandom_range(0, 63));
      wr = ($urandom_range(0, 3) == 0);
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(wr, rd, a, $urandom, int'($urandom_range(1, 4)), $urandom, got, st);
      idle(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
